// File: rtl/mem_access_stage_if.sv
// Bundle of the MEM stage's upstream handshake, data-memory ports and writeback handshake.
// The slave modport is the stage itself; the master modport is everything around it.
interface mem_access_stage_if #(
    parameter int unsigned NB_DATA_BUS = 32,
    parameter int unsigned NB_ADDRESS  = 6,
    parameter int unsigned NB_REG      = 5
);
    logic                   valid;
    logic                   ready;
    logic                   mem_read;
    logic                   mem_write;
    logic [1:0]             size;
    logic                   is_unsigned;
    logic [NB_ADDRESS-1:0]  addr;
    logic [NB_DATA_BUS-1:0] alu_result;
    logic [NB_DATA_BUS-1:0] store_data;
    logic [NB_REG-1:0]      rd;
    logic                   reg_write;

    logic [NB_ADDRESS-1:0]  mem_r_addr;
    logic                   mem_r_en;
    logic [1:0]             mem_r_addressing;
    logic [NB_DATA_BUS-1:0] mem_r_data;
    logic [NB_ADDRESS-1:0]  mem_w_addr;
    logic [NB_DATA_BUS-1:0] mem_w_data;
    logic                   mem_w_en;
    logic [1:0]             mem_w_addressing;

    logic                   wb_valid;
    logic                   wb_ready;
    logic [NB_DATA_BUS-1:0] wb_data;
    logic [NB_REG-1:0]      wb_rd;
    logic                   wb_reg_write;
    logic                   exc;

    modport slave (
        input  valid, mem_read, mem_write, size, is_unsigned, addr, alu_result, store_data,
               rd, reg_write, mem_r_data, wb_ready,
        output ready, mem_r_addr, mem_r_en, mem_r_addressing, mem_w_addr, mem_w_data,
               mem_w_en, mem_w_addressing, wb_valid, wb_data, wb_rd, wb_reg_write, exc
    );

    modport master (
        output valid, mem_read, mem_write, size, is_unsigned, addr, alu_result, store_data,
               rd, reg_write, mem_r_data, wb_ready,
        input  ready, mem_r_addr, mem_r_en, mem_r_addressing, mem_w_addr, mem_w_data,
               mem_w_en, mem_w_addressing, wb_valid, wb_data, wb_rd, wb_reg_write, exc
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: accepts one instruction, runs the synchronous memory access,
// extends load data and hands the result to writeback over a valid/ready handshake.
module mem_access_stage #(
    parameter int unsigned NB_DATA_BUS = 32,
    parameter int unsigned NB_ADDRESS  = 6,
    parameter int unsigned NB_REG      = 5
) (
    input logic                clk,
    input logic                rst_n,
    mem_access_stage_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StRdIssue, StRdCapture, StWrIssue, StWb} state_e;

    state_e                 state_q, state_d;
    logic [NB_ADDRESS-1:0]  r_addr_q, r_addr_d, w_addr_q, w_addr_d;
    logic [1:0]             r_addressing_q, r_addressing_d, w_addressing_q, w_addressing_d;
    logic [NB_DATA_BUS-1:0] w_data_q, w_data_d, wb_data_q, wb_data_d;
    logic                   r_en_q, r_en_d, w_en_q, w_en_d;
    logic                   wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
    logic                   exc_q, exc_d, unsigned_q, unsigned_d;
    logic [NB_REG-1:0]      wb_rd_q, wb_rd_d;

    logic                   misaligned, illegal;
    logic [NB_DATA_BUS-1:0] load_ext;

    // Alignment/legality only matters when the instruction touches memory.
    always_comb begin
        misaligned = ((bus.size == 2'b01) && bus.addr[0]) ||
                     ((bus.size == 2'b11) && (bus.addr[1:0] != 2'b00));
        illegal    = (bus.mem_read || bus.mem_write) &&
                     ((bus.size == 2'b10) || (bus.mem_read && bus.mem_write) || misaligned);
    end

    always_comb begin
        load_ext = bus.mem_r_data;
        unique case (r_addressing_q)
            2'b00:   load_ext = {{(NB_DATA_BUS-8){~unsigned_q & bus.mem_r_data[7]}},
                                bus.mem_r_data[7:0]};
            2'b01:   load_ext = {{(NB_DATA_BUS-16){~unsigned_q & bus.mem_r_data[15]}},
                                bus.mem_r_data[15:0]};
            default: load_ext = bus.mem_r_data;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        r_addr_d       = r_addr_q;
        w_addr_d       = w_addr_q;
        r_addressing_d = r_addressing_q;
        w_addressing_d = w_addressing_q;
        w_data_d       = w_data_q;
        wb_data_d      = wb_data_q;
        r_en_d         = 1'b0;
        w_en_d         = 1'b0;
        wb_valid_d     = wb_valid_q;
        wb_reg_write_d = wb_reg_write_q;
        exc_d          = exc_q;
        unsigned_d     = unsigned_q;
        wb_rd_d        = wb_rd_q;

        unique case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    r_addr_d       = bus.addr;
                    w_addr_d       = bus.addr;
                    r_addressing_d = bus.size;
                    w_addressing_d = bus.size;
                    w_data_d       = bus.store_data;
                    unsigned_d     = bus.is_unsigned;
                    wb_rd_d        = bus.rd;
                    wb_reg_write_d = bus.reg_write;
                    wb_data_d      = '0;
                    exc_d          = 1'b0;
                    if (illegal) begin
                        state_d        = StWb;
                        wb_valid_d     = 1'b1;
                        exc_d          = 1'b1;
                        wb_reg_write_d = 1'b0;
                    end else if (bus.mem_read) begin
                        state_d = StRdIssue;
                        r_en_d  = 1'b1;
                    end else if (bus.mem_write) begin
                        state_d        = StWrIssue;
                        w_en_d         = 1'b1;
                        wb_reg_write_d = 1'b0;
                    end else begin
                        state_d    = StWb;
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.alu_result;
                    end
                end
            end
            StRdIssue:   state_d = StRdCapture;
            // Memory registered its data at the previous edge; take it on the way out.
            StRdCapture: begin
                wb_data_d  = load_ext;
                wb_valid_d = 1'b1;
                state_d    = StWb;
            end
            StWrIssue: begin
                wb_valid_d = 1'b1;
                state_d    = StWb;
            end
            StWb: begin
                if (bus.wb_ready) begin
                    wb_valid_d = 1'b0;
                    exc_d      = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            r_addr_q       <= '0;
            w_addr_q       <= '0;
            r_addressing_q <= '0;
            w_addressing_q <= '0;
            w_data_q       <= '0;
            wb_data_q      <= '0;
            r_en_q         <= 1'b0;
            w_en_q         <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            exc_q          <= 1'b0;
            unsigned_q     <= 1'b0;
            wb_rd_q        <= '0;
        end else begin
            state_q        <= state_d;
            r_addr_q       <= r_addr_d;
            w_addr_q       <= w_addr_d;
            r_addressing_q <= r_addressing_d;
            w_addressing_q <= w_addressing_d;
            w_data_q       <= w_data_d;
            wb_data_q      <= wb_data_d;
            r_en_q         <= r_en_d;
            w_en_q         <= w_en_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            exc_q          <= exc_d;
            unsigned_q     <= unsigned_d;
            wb_rd_q        <= wb_rd_d;
        end
    end

    // Ready is gated by reset so upstream never sees a transfer window while held in reset.
    assign bus.ready            = (state_q == StIdle) && rst_n;
    assign bus.mem_r_addr       = r_addr_q;
    assign bus.mem_r_en         = r_en_q;
    assign bus.mem_r_addressing = r_addressing_q;
    assign bus.mem_w_addr       = w_addr_q;
    assign bus.mem_w_data       = w_data_q;
    assign bus.mem_w_en         = w_en_q;
    assign bus.mem_w_addressing = w_addressing_q;
    assign bus.wb_valid         = wb_valid_q;
    assign bus.wb_data          = wb_data_q;
    assign bus.wb_rd            = wb_rd_q;
    assign bus.wb_reg_write     = wb_reg_write_q;
    assign bus.exc              = exc_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a byte-addressed synchronous memory model
// standing in for combined_memory.
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_bad    = 0;
    int   r_pulses = 0;
    int   w_pulses = 0;
    logic [1:0]  last_w_addressing = 2'b00;
    logic [31:0] last_w_data = '0;
    logic [7:0]  mem [64];

    always #5 clk = ~clk;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] rd_word(input logic [5:0] a);
        return {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    endfunction

    // Read data always carries four bytes so the stage's own masking is exercised.
    always @(posedge clk) begin
        if (bus.mem_r_en) begin
            bus.mem_r_data <= rd_word(bus.mem_r_addr);
            r_pulses       <= r_pulses + 1;
        end
        if (bus.mem_w_en) begin
            w_pulses          <= w_pulses + 1;
            last_w_addressing <= bus.mem_w_addressing;
            last_w_data       <= bus.mem_w_data;
            mem[bus.mem_w_addr] <= bus.mem_w_data[7:0];
            if (bus.mem_w_addressing != 2'b00)
                mem[bus.mem_w_addr + 6'd1] <= bus.mem_w_data[15:8];
            if (bus.mem_w_addressing == 2'b11) begin
                mem[bus.mem_w_addr + 6'd2] <= bus.mem_w_data[23:16];
                mem[bus.mem_w_addr + 6'd3] <= bus.mem_w_data[31:24];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic rd_op, input logic wr_op,
                         input logic [1:0] sz, input logic uns, input logic [5:0] a,
                         input logic [31:0] alu, input logic [31:0] sd, input int exp_lat,
                         input logic exp_exc, input logic exp_rw, input int exp_r,
                         input int exp_w, input logic chk_data, input logic [31:0] exp_data);
        int lat, r0, w0;
        @(negedge clk);
        bus.mem_read    = rd_op;
        bus.mem_write   = wr_op;
        bus.size        = sz;
        bus.is_unsigned = uns;
        bus.addr        = a;
        bus.alu_result  = alu;
        bus.store_data  = sd;
        bus.rd          = 5'd7;
        bus.reg_write   = 1'b1;
        bus.valid       = 1'b1;
        r0 = r_pulses;
        w0 = w_pulses;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        lat = 1;
        while (!bus.wb_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_exc"}, 32'(bus.exc), 32'(exp_exc));
        check_eq({tag, "_reg_write"}, 32'(bus.wb_reg_write), 32'(exp_rw));
        check_eq({tag, "_r_pulses"}, 32'(r_pulses - r0), 32'(exp_r));
        check_eq({tag, "_w_pulses"}, 32'(w_pulses - w0), 32'(exp_w));
        check_eq({tag, "_rd"}, 32'(bus.wb_rd), 32'd7);
        if (chk_data) check_eq({tag, "_data"}, bus.wb_data, exp_data);
        @(posedge clk);
        #1;
        check_eq({tag, "_back_idle"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.size = 2'b00;
        bus.is_unsigned = 1'b0; bus.addr = '0; bus.alu_result = '0; bus.store_data = '0;
        bus.rd = '0; bus.reg_write = 1'b0; bus.wb_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(bus.ready), 32'd0);
        check_eq("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check_eq("rst_r_en", 32'(bus.mem_r_en), 32'd0);
        check_eq("rst_w_en", 32'(bus.mem_w_en), 32'd0);
        check_eq("rst_exc", 32'(bus.exc), 32'd0);
        check_eq("rst_wb_data", bus.wb_data, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("release_ready", 32'(bus.ready), 32'd1);

        //     tag    rd    wr    sz     uns   addr   alu   store         lat exc rw r w chk data
        do_op("sw0", 1'b0, 1'b1, 2'b11, 1'b0, 6'h00, '0, 32'h0123ABCD, 2, 0, 0, 0, 1, 0, '0);
        check_eq("sw0_w_addressing", 32'(last_w_addressing), 32'd3);
        check_eq("sw0_w_data", last_w_data, 32'h0123ABCD);
        do_op("lw0", 1'b1, 1'b0, 2'b11, 1'b0, 6'h00, '0, '0, 3, 0, 1, 1, 0, 1, 32'h0123ABCD);

        do_op("sw4", 1'b0, 1'b1, 2'b11, 1'b0, 6'h04, '0, 32'h0000ABCD, 2, 0, 0, 0, 1, 0, '0);
        do_op("lh4", 1'b1, 1'b0, 2'b01, 1'b0, 6'h04, '0, '0, 3, 0, 1, 1, 0, 1, 32'hFFFFABCD);
        do_op("lhu4", 1'b1, 1'b0, 2'b01, 1'b1, 6'h04, '0, '0, 3, 0, 1, 1, 0, 1, 32'h0000ABCD);
        do_op("lb4", 1'b1, 1'b0, 2'b00, 1'b0, 6'h04, '0, '0, 3, 0, 1, 1, 0, 1, 32'hFFFFFFCD);
        do_op("lbu4", 1'b1, 1'b0, 2'b00, 1'b1, 6'h04, '0, '0, 3, 0, 1, 1, 0, 1, 32'h000000CD);
        do_op("lbu1", 1'b1, 1'b0, 2'b00, 1'b1, 6'h01, '0, '0, 3, 0, 1, 1, 0, 1, 32'h000000AB);

        do_op("lh9", 1'b1, 1'b0, 2'b01, 1'b0, 6'h09, '0, '0, 1, 1, 0, 0, 0, 0, '0);
        do_op("swa", 1'b0, 1'b1, 2'b11, 1'b0, 6'h0A, '0, 32'h55, 1, 1, 0, 0, 0, 0, '0);
        do_op("sz10", 1'b1, 1'b0, 2'b10, 1'b0, 6'h00, '0, '0, 1, 1, 0, 0, 0, 0, '0);
        do_op("alu", 1'b0, 1'b0, 2'b10, 1'b0, 6'h03, 32'hDEADBEEF, '0, 1, 0, 1, 0, 0, 1,
              32'hDEADBEEF);

        // Writeback backpressure on a word load.
        bus.wb_ready = 1'b0;
        @(negedge clk);
        bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.size = 2'b11; bus.addr = 6'h00;
        bus.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        for (int i = 0; i < 10 && !bus.wb_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_wb_valid", 32'(bus.wb_valid), 32'd1);
            check_eq("bp_wb_data", bus.wb_data, 32'h0123ABCD);
            check_eq("bp_ready", 32'(bus.ready), 32'd0);
        end
        @(negedge clk);
        bus.wb_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_ready", 32'(bus.ready), 32'd1);
        check_eq("bp_release_wb_valid", 32'(bus.wb_valid), 32'd0);

        // Reset while a byte store is in its issue cycle.
        @(negedge clk);
        bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.size = 2'b00; bus.addr = 6'h01;
        bus.store_data = 32'h000000EE; bus.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        check_eq("sb_w_en_up", 32'(bus.mem_w_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("sb_w_en_drop", 32'(bus.mem_w_en), 32'd0);
        check_eq("sb_rst_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("sb_release_ready", 32'(bus.ready), 32'd1);
        do_op("lbu1_after", 1'b1, 1'b0, 2'b00, 1'b1, 6'h01, '0, '0, 3, 0, 1, 1, 0, 1,
              32'h000000AB);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
